// File: rtl/message_overlay_if.sv
// Control, pixel-coordinate and glyph-ROM signals of the text overlay.
// The game side drives the master end; the overlay block is the slave.
interface message_overlay_if #(
   parameter int MW    = 2,
   parameter int RW    = 4,
   parameter int MSG_W = 32
);
   logic              trigger;
   logic [MW-1:0]     msg_sel;
   logic              blink_en;
   logic              cancel;
   logic [9:0]        pixel_x;
   logic [8:0]        pixel_y;
   logic [MW+RW-1:0]  rom_addr;
   logic [MSG_W-1:0]  rom_data;
   logic              overlay_on;
   logic              busy;
   logic [MW-1:0]     active_msg;
   logic              msg_done;

   modport master (
      output trigger, msg_sel, blink_en, cancel, pixel_x, pixel_y, rom_data,
      input  rom_addr, overlay_on, busy, active_msg, msg_done
   );

   modport slave (
      input  trigger, msg_sel, blink_en, cancel, pixel_x, pixel_y, rom_data,
      output rom_addr, overlay_on, busy, active_msg, msg_done
   );
endinterface

// File: rtl/message_overlay.sv
// Bitmap text overlay: shows one ROM message, scaled by 2^SCALE_SHIFT, for a fixed time.
// The blink phase and the pixel pipeline are aligned to the one-cycle latency of the glyph ROM.
module message_overlay #(
   parameter int NUM_MSGS       = 4,
   parameter int MSG_W          = 32,
   parameter int MSG_H          = 16,
   parameter int SCALE_SHIFT    = 3,
   parameter int START_X        = 192,
   parameter int START_Y        = 176,
   parameter int DISPLAY_CYCLES = 250000000,
   parameter int BLINK_CYCLES   = 25000000
) (
   input logic               clk,
   input logic               reset,
   message_overlay_if.slave  bus
);
   localparam int MW = $clog2(NUM_MSGS);
   localparam int RW = $clog2(MSG_H);
   localparam int CW = $clog2(MSG_W);
   localparam int TW = $clog2(DISPLAY_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);

   localparam logic [10:0]   X_LO   = 11'(START_X);
   localparam logic [10:0]   X_HI   = 11'(START_X + (MSG_W << SCALE_SHIFT));
   localparam logic [9:0]    Y_LO   = 10'(START_Y);
   localparam logic [9:0]    Y_HI   = 10'(START_Y + (MSG_H << SCALE_SHIFT));
   localparam logic [TW-1:0] T_LAST = TW'(DISPLAY_CYCLES - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SHOW = 1'b1} state_t;

   state_t          state_r, state_nx;
   logic [TW-1:0]   timer_r;
   logic [BW-1:0]   blink_cnt_r;
   logic            phase_r;
   logic            blink_en_r;
   logic [MW-1:0]   msg_r;
   logic            done_r;
   logic            load_s;
   logic            done_s;

   logic [9:0]      rel_x_s;
   logic [8:0]      rel_y_s;
   logic [RW-1:0]   row_s;
   logic [CW-1:0]   bit_idx_s;
   logic            in_win_s;

   logic [CW-1:0]   bit_idx_r;
   logic            in_win_r;
   logic            valid_r;

   // Next state; cancel outranks trigger, and a trigger on the expiry cycle restarts instead of finishing.
   always_comb begin
      state_nx = state_r;
      load_s   = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.trigger && !bus.cancel) begin
               state_nx = SHOW;
               load_s   = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         SHOW: begin
            if (bus.cancel) begin
               state_nx = IDLE;
            end else if (bus.trigger) begin
               state_nx = SHOW;
               load_s   = 1'b1;
            end else if (timer_r == T_LAST) begin
               state_nx = IDLE;
               done_s   = 1'b1;
            end else begin
               state_nx = SHOW;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, display timer, blink phase and latched message parameters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         timer_r     <= '0;
         blink_cnt_r <= '0;
         phase_r     <= 1'b1;
         blink_en_r  <= 1'b0;
         msg_r       <= '0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_nx;
         done_r  <= done_s;
         if (load_s) begin
            timer_r     <= '0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
            blink_en_r  <= bus.blink_en;
            msg_r       <= bus.msg_sel;
         end else if (state_r == SHOW) begin
            timer_r <= timer_r + TW'(1);
            if (blink_en_r) begin
               if (blink_cnt_r == B_LAST) begin
                  blink_cnt_r <= '0;
                  phase_r     <= ~phase_r;
               end else begin
                  blink_cnt_r <= blink_cnt_r + BW'(1);
               end
            end
         end
      end
   end

   // Window test on full-width coordinates so pixels left of or above the window cannot wrap in.
   always_comb begin
      rel_x_s   = bus.pixel_x - X_LO[9:0];
      rel_y_s   = bus.pixel_y - Y_LO[8:0];
      row_s     = RW'(rel_y_s >> SCALE_SHIFT);
      bit_idx_s = CW'(MSG_W - 1) - CW'(rel_x_s >> SCALE_SHIFT);
      in_win_s  = ({1'b0, bus.pixel_x} >= X_LO) && ({1'b0, bus.pixel_x} < X_HI) &&
                  ({1'b0, bus.pixel_y} >= Y_LO) && ({1'b0, bus.pixel_y} < Y_HI);
   end

   // Pixel stage that waits out the ROM read.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_idx_r <= '0;
         in_win_r  <= 1'b0;
         valid_r   <= 1'b0;
      end else begin
         bit_idx_r <= bit_idx_s;
         in_win_r  <= in_win_s;
         valid_r   <= (state_r == SHOW) && (!blink_en_r || phase_r);
      end
   end

   assign bus.rom_addr   = {msg_r, row_s};
   // Only registered terms are combined here: the stage-1 flops and the ROM's output word.
   assign bus.overlay_on = valid_r & in_win_r & bus.rom_data[bit_idx_r];
   assign bus.busy       = (state_r == SHOW);
   assign bus.active_msg = msg_r;
   assign bus.msg_done   = done_r;
endmodule

// File: tb/tb_message_overlay.sv
// Self-checking bench for message_overlay: overlay pixels are scored through an expectation queue,
// timing and control outputs are compared cycle by cycle.
module tb_message_overlay;
   localparam int SX = 192;
   localparam int SY = 176;
   localparam int DC = 100;
   localparam int BC = 10;

   typedef struct {
      int   due;
      logic exp;
      int   tag;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   sb_t  sb[$];

   message_overlay_if #(.MW(2), .RW(4), .MSG_W(32)) bus ();

   message_overlay #(
      .NUM_MSGS(4), .MSG_W(32), .MSG_H(16), .SCALE_SHIFT(3), .START_X(SX), .START_Y(SY),
      .DISPLAY_CYCLES(DC), .BLINK_CYCLES(BC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Glyph ROM: one-cycle latency, message k row r holds 32'hA5A5_0000 | {k,r}.
   always @(posedge clk) bus.rom_data <= 32'hA5A5_0000 | {26'd0, bus.rom_addr};

   function automatic logic model_pix(input int x, input int y, input int msg);
      logic [31:0] word;
      int col;
      int row;
      if (x < SX || x >= SX + 256 || y < SY || y >= SY + 128) return 1'b0;
      col  = (x - SX) >> 3;
      row  = (y - SY) >> 3;
      word = 32'hA5A5_0000 | 32'((msg << 4) | row);
      return word[5'(31 - col)];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.msg_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.msg_done); end
      n_cmp++; if (bus.overlay_on !== 1'b0) begin n_err++; $display("FAIL reset_overlay: got %b expected 0", bus.overlay_on); end
      n_cmp++; if (bus.active_msg !== 2'd0) begin n_err++; $display("FAIL reset_msg: got %0d expected 0", bus.active_msg); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      sb_t it;
      int  x;
      int  y;
      @(posedge clk); #1;
      bus.trigger = 1'b1; bus.msg_sel = 2'd2; bus.blink_en = 1'b0;
      bus.pixel_x = 10'(SX); bus.pixel_y = 9'(SY);
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      sb.push_back('{cyc + 1, model_pix(SX, SY, 2), 0});
      @(negedge clk);
      n_cmp++; if (bus.rom_addr !== 6'b10_0000) begin n_err++; $display("FAIL basic_rom_addr: got %b expected 100000", bus.rom_addr); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
      n_cmp++; if (bus.active_msg !== 2'd2) begin n_err++; $display("FAIL basic_msg: got %0d expected 2", bus.active_msg); end
      for (int i = 1; i <= 17; i++) begin
         @(posedge clk); #1;
         if (i <= 16) begin
            x = SX + 8 * (((i - 1) * 5) % 32) + (i % 8);
            y = SY + 8 * (i - 1) + (i % 8);
            bus.pixel_x = 10'(x); bus.pixel_y = 9'(y);
            sb.push_back('{cyc + 1, model_pix(x, y, 2), i});
         end
         @(negedge clk);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            n_cmp++;
            if (bus.overlay_on !== it.exp) begin n_err++; $display("FAIL basic_pix[%0d]: got %b expected %b", it.tag, bus.overlay_on, it.exp); end
         end
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL basic_sb_left: got %0d expected 0", sb.size()); sb.delete(); end
      @(posedge clk); #1; bus.cancel = 1'b1;
      @(posedge clk); #1; bus.cancel = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_cancel_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_done();
      int   t0;
      int   k;
      logic eb;
      logic ed;
      @(posedge clk); #1;
      bus.trigger = 1'b1; bus.msg_sel = 2'd0; bus.blink_en = 1'b0;
      t0 = cyc;
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      repeat (103) begin
         @(negedge clk);
         k  = cyc - t0;
         eb = (k <= DC);
         ed = (k == DC + 1);
         n_cmp++; if (bus.busy !== eb) begin n_err++; $display("FAIL done_busy@%0d: got %b expected %b", k, bus.busy, eb); end
         n_cmp++; if (bus.msg_done !== ed) begin n_err++; $display("FAIL done_pulse@%0d: got %b expected %b", k, bus.msg_done, ed); end
      end
   endtask

   task automatic test_window();
      sb_t it;
      int  xs[8] = '{SX + 255, SX + 256, SX - 1, SX + 255, SX + 255, SX + 255, SX, SX + 255};
      int  ys[8] = '{SY + 8, SY + 8, SY + 8, SY + 127, SY + 128, SY - 1, SY + 127, SY};
      @(posedge clk); #1;
      bus.trigger = 1'b1; bus.msg_sel = 2'd3; bus.blink_en = 1'b0;
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (i < 8) begin
            bus.pixel_x = 10'(xs[i]); bus.pixel_y = 9'(ys[i]);
            sb.push_back('{cyc + 1, model_pix(xs[i], ys[i], 3), i});
         end
         @(negedge clk);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            n_cmp++;
            if (bus.overlay_on !== it.exp) begin n_err++; $display("FAIL window_pix[%0d]: got %b expected %b", it.tag, bus.overlay_on, it.exp); end
         end
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL window_sb_left: got %0d expected 0", sb.size()); sb.delete(); end
      @(posedge clk); #1; bus.cancel = 1'b1;
      @(posedge clk); #1; bus.cancel = 1'b0;
   endtask

   task automatic test_blink();
      sb_t  it;
      logic e;
      for (int run = 0; run < 2; run++) begin
         for (int k = 0; k <= 36; k++) begin
            @(posedge clk); #1;
            bus.trigger = (k == 0);
            if (k == 0) begin
               bus.msg_sel = 2'd1; bus.blink_en = (run == 0);
               bus.pixel_x = 10'(SX); bus.pixel_y = 9'(SY);
            end
            if (k < 36) begin
               // The pixel of cycle k after the trigger is hidden for k = 11..20 while blinking.
               if (k == 0) e = 1'b0;
               else if (run == 1) e = 1'b1;
               else e = (((k - 1) / BC) % 2 == 0);
               sb.push_back('{cyc + 1, e, k});
            end
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
               it = sb.pop_front();
               n_cmp++;
               if (bus.overlay_on !== it.exp) begin n_err++; $display("FAIL blink%0d_pix[%0d]: got %b expected %b", run, it.tag, bus.overlay_on, it.exp); end
            end
         end
         n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL blink_sb_left: got %0d expected 0", sb.size()); sb.delete(); end
         @(posedge clk); #1; bus.cancel = 1'b1;
         @(posedge clk); #1; bus.cancel = 1'b0;
      end
      bus.blink_en = 1'b0;
   endtask

   task automatic test_restart();
      int   t0;
      logic eb;
      logic ed;
      @(posedge clk); #1;
      bus.trigger = 1'b1; bus.msg_sel = 2'd0; bus.blink_en = 1'b0;
      t0 = cyc;
      for (int k = 1; k <= 153; k++) begin
         @(posedge clk); #1;
         bus.trigger = (k == 50);
         bus.msg_sel = (k == 50) ? 2'd1 : 2'd0;
         @(negedge clk);
         eb = (k <= 150);
         ed = (k == 151);
         n_cmp++; if (bus.busy !== eb) begin n_err++; $display("FAIL restart_busy@%0d: got %b expected %b", k, bus.busy, eb); end
         n_cmp++; if (bus.msg_done !== ed) begin n_err++; $display("FAIL restart_done@%0d: got %b expected %b", k, bus.msg_done, ed); end
         if (k == 51) begin
            n_cmp++; if (bus.active_msg !== 2'd1) begin n_err++; $display("FAIL restart_msg: got %0d expected 1", bus.active_msg); end
         end
      end
      n_cmp++; if (cyc - t0 !== 153) begin n_err++; $display("FAIL restart_len: got %0d expected 153", cyc - t0); end
   endtask

   task automatic test_cancel_reset();
      logic seen_done;
      logic seen_busy;
      seen_done = 1'b0; seen_busy = 1'b0;
      for (int k = 0; k <= 110; k++) begin
         @(posedge clk); #1;
         bus.trigger = (k == 0) || (k == 20);
         bus.cancel  = (k == 20);
         bus.msg_sel = 2'd2;
         @(negedge clk);
         if (k == 21) begin
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b expected 0", bus.busy); end
         end
         if (k > 21 && bus.busy === 1'b1) seen_busy = 1'b1;
         if (bus.msg_done === 1'b1) seen_done = 1'b1;
      end
      n_cmp++; if (seen_busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy_later: got %b expected 0", seen_busy); end
      n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL cancel_done: got %b expected 0", seen_done); end

      seen_done = 1'b0;
      bus.pixel_x = 10'(SX); bus.pixel_y = 9'(SY);
      for (int k = 0; k <= 150; k++) begin
         @(posedge clk); #1;
         bus.trigger = (k == 0);
         bus.msg_sel = 2'd3;
         reset       = (k == 41);
         @(negedge clk);
         if (k == 41) begin
            n_cmp++; if (bus.overlay_on !== 1'b1) begin n_err++; $display("FAIL prereset_overlay: got %b expected 1", bus.overlay_on); end
            n_cmp++; if (bus.active_msg !== 2'd3) begin n_err++; $display("FAIL prereset_msg: got %0d expected 3", bus.active_msg); end
         end
         if (k == 42) begin
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
            n_cmp++; if (bus.overlay_on !== 1'b0) begin n_err++; $display("FAIL midreset_overlay: got %b expected 0", bus.overlay_on); end
            n_cmp++; if (bus.active_msg !== 2'd0) begin n_err++; $display("FAIL midreset_msg: got %0d expected 0", bus.active_msg); end
            n_cmp++; if (bus.msg_done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", bus.msg_done); end
         end
         if (bus.msg_done === 1'b1) seen_done = 1'b1;
      end
      n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL midreset_no_done: got %b expected 0", seen_done); end
   endtask

   initial begin
      reset        = 1'b1;
      bus.trigger  = 1'b0;
      bus.msg_sel  = 2'd0;
      bus.blink_en = 1'b0;
      bus.cancel   = 1'b0;
      bus.pixel_x  = 10'd0;
      bus.pixel_y  = 9'd0;
      test_reset();
      test_basic();
      test_done();
      test_window();
      test_blink();
      test_restart();
      test_cancel_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
